step_pulse_decoder: RTL and testbench

Receive-side counterpart of the stepper-motor step pulse generator. The block accepts a step/direction pulse train, either looped back from the generator output or taken from a driver monitor pin. It synchronises both inputs to the 50 MHz clock, qualifies each step pulse by its high time, and keeps a signed position and a step count against a loadable target. It also measures the step period and flags stalls, so firmware can close the loop on the commanded moves.

---
 rtl/step_pulse_decoder.sv | 139 +++++++++++++
 tb/tb_step_pulse_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/step_pulse_decoder.sv
// Step/direction pulse-train decoder: synchronises, qualifies pulses,
// tracks signed position, step count vs target, step period and stalls.
module step_pulse_decoder #(
  parameter int SIZE     = 16,
  parameter int POS_W    = 32,
  parameter int MIN_HIGH = 2,
  parameter int TIMEOUT  = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    step_in,
  input  logic                    dir_in,
  input  logic                    clr,
  input  logic                    d_v,
  input  logic [SIZE-1:0]         target,
  output logic signed [POS_W-1:0] position,
  output logic [SIZE-1:0]         step_cnt,
  output logic                    step_v,
  output logic [SIZE-1:0]         period,
  output logic [SIZE-1:0]         high_len,
  output logic                    done,
  output logic                    stall,
  output logic                    glitch
);

  localparam logic [SIZE-1:0]  MINH  = SIZE'(MIN_HIGH);
  localparam logic [SIZE-1:0]  TOUT  = SIZE'(TIMEOUT);
  localparam logic [SIZE-1:0]  ONES  = '1;
  localparam logic [SIZE-1:0]  ONE   = SIZE'(1);
  localparam logic [POS_W-1:0] P_INC = POS_W'(1);
  localparam logic [POS_W-1:0] P_DEC = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STALL
  } state_t;

  state_t state, nxt;

  logic stp_s1, stp_s2, stp_s3;
  logic dir_s1, dir_s2;
  logic rise, fall, accept, reject;
  logic per_wr;

  logic [SIZE-1:0] per_cnt;
  logic [SIZE-1:0] hi_cnt;
  logic [SIZE-1:0] tgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stp_s1 <= 1'b0;
      stp_s2 <= 1'b0;
      stp_s3 <= 1'b0;
      dir_s1 <= 1'b0;
      dir_s2 <= 1'b0;
    end else begin
      stp_s1 <= step_in;
      stp_s2 <= stp_s1;
      stp_s3 <= stp_s2;
      dir_s1 <= dir_in;
      dir_s2 <= dir_s1;
    end
  end

  assign rise   = stp_s2 & ~stp_s3;
  assign fall   = ~stp_s2 & stp_s3;
  assign accept = fall & (hi_cnt >= MINH);
  assign reject = fall & (hi_cnt < MINH);

  always_comb begin
    nxt    = state;
    per_wr = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) nxt = RUN;
      end
      RUN: begin
        if (rise) per_wr = 1'b1;
        else if (per_cnt == TOUT) nxt = STALL;
      end
      STALL: begin
        if (rise) nxt = RUN;
      end
      default: nxt = IDLE;
    endcase
    if (clr) nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
      period  <= '0;
    end else begin
      if (rise)               per_cnt <= ONE;
      else if (per_cnt != ONES) per_cnt <= per_cnt + ONE;
      if (rise)                         hi_cnt <= ONE;
      else if (stp_s2 && hi_cnt != ONES) hi_cnt <= hi_cnt + ONE;
      if (per_wr) period <= per_cnt;
    end
  end

  // clr overrides an accepted step; d_v only zeroes the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position <= '0;
      step_cnt <= '0;
      high_len <= '0;
      step_v   <= 1'b0;
      glitch   <= 1'b0;
      tgt      <= '0;
    end else begin
      step_v <= accept & ~clr;
      if (d_v) tgt <= target;
      if (clr) begin
        position <= '0;
        glitch   <= 1'b0;
      end else begin
        if (accept) position <= position + (dir_s2 ? P_INC : P_DEC);
        if (reject) glitch <= 1'b1;
      end
      if (clr || d_v)
        step_cnt <= '0;
      else if (accept && step_cnt != ONES)
        step_cnt <= step_cnt + ONE;
      if (accept && !clr) high_len <= hi_cnt;
    end
  end

  assign done  = (step_cnt == tgt) && (tgt != '0);
  assign stall = (state == STALL);

endmodule

// File: tb/tb_step_pulse_decoder.sv
// Directed bench for step_pulse_decoder using narrow widths so that
// wrap, saturation and stall timeout are reachable in few cycles.
module tb_step_pulse_decoder;

  localparam int SIZE     = 8;
  localparam int POS_W    = 8;
  localparam int MIN_HIGH = 2;
  localparam int TIMEOUT  = 200;

  logic             clk;
  logic             rst;
  logic             step_in;
  logic             dir_in;
  logic             clr;
  logic             d_v;
  logic [SIZE-1:0]  target;
  logic [POS_W-1:0] position;
  logic [SIZE-1:0]  step_cnt;
  logic             step_v;
  logic [SIZE-1:0]  period;
  logic [SIZE-1:0]  high_len;
  logic             done;
  logic             stall;
  logic             glitch;

  int errors = 0;
  int checks = 0;
  int sv_cnt = 0;
  int sv_ref;
  logic sv_done = 1'b0;

  step_pulse_decoder #(
    .SIZE(SIZE),
    .POS_W(POS_W),
    .MIN_HIGH(MIN_HIGH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .step_in(step_in),
    .dir_in(dir_in),
    .clr(clr),
    .d_v(d_v),
    .target(target),
    .position(position),
    .step_cnt(step_cnt),
    .step_v(step_v),
    .period(period),
    .high_len(high_len),
    .done(done),
    .stall(stall),
    .glitch(glitch)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (step_v) begin
      sv_cnt  <= sv_cnt + 1;
      sv_done <= done;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // high for h cycles, low for l cycles; l >= 4 lets step_v settle
  task automatic pulse(input int h, input int l);
    @(negedge clk);
    step_in = 1'b1;
    repeat (h - 1) @(negedge clk);
    @(negedge clk);
    step_in = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    step_in = 1'b0;
    dir_in = 1'b1;
    clr = 1'b0;
    d_v = 1'b0;
    target = '0;
    cyc(3);
    chk("rst_pos", 32'(position), 32'd0);
    chk("rst_cnt", 32'(step_cnt), 32'd0);
    chk("rst_flags", {28'd0, step_v, done, stall, glitch}, 32'd0);
    rst = 1'b0;
    cyc(3);

    repeat (10) pulse(4, 16);
    chk("t1_pos", 32'(position), 32'd10);
    chk("t1_cnt", 32'(step_cnt), 32'd10);
    chk("t1_period", 32'(period), 32'd20);
    chk("t1_high", 32'(high_len), 32'd4);
    chk("t1_strobes", 32'(sv_cnt), 32'd10);
    chk("t1_glitch_stall", {30'd0, glitch, stall}, 32'd0);

    @(negedge clk);
    clr = 1'b1;
    d_v = 1'b1;
    target = 8'd5;
    dir_in = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    d_v = 1'b0;
    cyc(4);
    chk("t2_clr_dv", 32'(step_cnt), 32'd0);
    repeat (4) pulse(4, 16);
    chk("t2_cnt4", 32'(step_cnt), 32'd4);
    chk("t2_done4", 32'(done), 32'd0);
    pulse(4, 16);
    chk("t2_done_at_sv", 32'(sv_done), 32'd1);
    chk("t2_done5", 32'(done), 32'd1);
    chk("t2_pos", 32'(position), 32'hFB);
    pulse(4, 16);
    chk("t2_cnt6", 32'(step_cnt), 32'd6);
    chk("t2_done6", 32'(done), 32'd0);

    sv_ref = sv_cnt;
    pulse(1, 10);
    chk("t3_glitch", 32'(glitch), 32'd1);
    chk("t3_pos", 32'(position), 32'hFA);
    chk("t3_strobes", 32'(sv_cnt), 32'(sv_ref));
    cyc(5);
    chk("t3_sticky", 32'(glitch), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t3_clr", 32'(glitch), 32'd0);

    dir_in = 1'b1;
    cyc(4);
    repeat (3) pulse(4, 96);
    chk("t4_period", 32'(period), 32'd100);
    chk("t4_run", 32'(stall), 32'd0);
    @(negedge clk);
    step_in = 1'b1;
    cyc(4);
    step_in = 1'b0;
    cyc(TIMEOUT + 2 - 4);
    chk("t4_pre_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("t4_stall", 32'(stall), 32'd1);
    cyc(300 - (TIMEOUT + 3));
    chk("t4_stall_hold", 32'(stall), 32'd1);
    pulse(4, 96);
    chk("t4_unstall", 32'(stall), 32'd0);
    chk("t4_period_kept", 32'(period), 32'd100);
    pulse(4, 96);
    chk("t4_period_next", 32'(period), 32'd100);

    @(negedge clk);
    step_in = 1'b1;
    cyc(4);
    step_in = 1'b0;
    cyc(2);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t5_pos", 32'(position), 32'd0);
    chk("t5_cnt", 32'(step_cnt), 32'd0);
    cyc(10);
    pulse(4, 30);
    chk("t5_idle_period", 32'(period), 32'd100);
    pulse(4, 30);
    chk("t5_run_period", 32'(period), 32'd34);

    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (127) pulse(2, 4);
    chk("t6_pos_max", 32'(position), 32'h7F);
    chk("t6_high", 32'(high_len), 32'd2);
    pulse(2, 4);
    chk("t6_pos_wrap", 32'(position), 32'h80);
    chk("t6_cnt128", 32'(step_cnt), 32'd128);
    repeat (127) pulse(2, 4);
    chk("t6_cnt_full", 32'(step_cnt), 32'd255);
    pulse(2, 4);
    chk("t6_cnt_sat", 32'(step_cnt), 32'd255);
    chk("t6_pos_256", 32'(position), 32'd0);

    @(negedge clk);
    step_in = 1'b1;
    cyc(3);
    #2 rst = 1'b1;
    #1;
    chk("t7_async_period", 32'(period), 32'd0);
    chk("t7_async_cnt", 32'(step_cnt), 32'd0);
    chk("t7_async_high", 32'(high_len), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sv_ref = sv_cnt;
    @(negedge clk);
    step_in = 1'b0;
    cyc(6);
    chk("t7_partial_glitch", 32'(glitch), 32'd1);
    chk("t7_partial_cnt", 32'(step_cnt), 32'd0);
    chk("t7_partial_sv", 32'(sv_cnt), 32'(sv_ref));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
